buffer_in: RTL and testbench
============================

Name: buffer_in

Overview:
- Single-entry Tomasulo reservation buffer in front of one functional unit (adder, logic, jump, DM, ...).
- Accepts an issued instruction tagged for its own device.
- Snoops the common data bus (CDB) to resolve pending operands.
- Presents the instruction to the unit once both operands are ready and the unit is free.
- Contains a combinational operand-update function ("fetch CDB") applied to both operands.

Parameters:
- None. Device identity comes from the device_now port, which is tied to a constant (a codebase DEVICE_* code) at instantiation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_hasInput  in  1  issue stage presents an instruction this cycle.
- in_device  in  3  target device code of the issued instruction.
- in_algorithm  in  2  operation select for the unit (e.g. ADDER_ALGO_ADD).
- in_valueA  in  36  operand A: {ready[35], tag[34:32], value[31:0]}.
- in_valueB  in  36  operand B, same format.
- device_now  in  3  this buffer's device code (constant).
- cdb_buzy  in  1  CDB carries a valid broadcast this cycle.
- cdb_device  in  3  producing device tag of the broadcast.
- cdb_value  in  32  broadcast result.
- nxt_buzy  in  1  downstream functional unit busy; cannot accept.
- out_buzy  out  1  entry occupied.
- out_ready  out  1  entry occupied and both operands ready.
- out_algorithm  out  2  stored operation.
- out_valueA  out  36  stored operand A.
- out_valueB  out  36  stored operand B.

Behaviour:
- Operand format: ready=1 means value[31:0] is valid and the tag is don't-care. ready=0 means the operand waits for the device named by tag.
- Fetch-CDB function, combinational, per operand (op):
  - If op.ready=0 and cdb_buzy=1 and cdb_device==op.tag, result = {1'b1, 3'b000, cdb_value}.
  - Otherwise result = op unchanged. An already-ready operand is never overwritten.
- State registers: buzy, algorithm[1:0], A[35:0], B[35:0]. All outputs are driven directly from these registers, except out_ready.
- out_ready = buzy & A[35] & B[35]. Combinational from registers; no CDB bypass to the output.
- Reset: when rst=1 at a clock edge, buzy, algorithm, A and B all clear to 0. rst has priority over every other action, including mid-wait or during dispatch.
- Per clock edge, with rst=0, priority order:
  1. Dispatch: if buzy=1 and out_ready=1 and nxt_buzy=0, the unit consumes out_* this cycle. Next state: buzy=0, algorithm=0, A=0, B=0.
  2. Hold and snoop: else if buzy=1, algorithm holds; A <= fetch(A), B <= fetch(B).
  3. Accept: else if buzy=0 and in_hasInput=1 and in_device==device_now, next state is buzy=1, algorithm=in_algorithm, A=fetch(in_valueA), B=fetch(in_valueB). A value broadcast on the same cycle is captured at issue.
  4. Idle: otherwise the state is unchanged (remains zero).
- While buzy=1, issue input is ignored regardless of in_device. This includes the dispatch cycle: no same-cycle refill. Issue logic must check out_buzy.
- Latencies:
  - Accept → out_buzy=1 after 1 edge.
  - CDB broadcast → operand ready after 1 edge.
  - Ready and nxt_buzy=0 → out_buzy=0 after 1 edge.
- Both operands can resolve in the same cycle if both tags match the broadcast.
- nxt_buzy is don't-care while out_ready=0.
- No overflow/wrap concerns: single entry, no arithmetic.

Test Plan:
1. Fetch-CDB isolation, with cdb_buzy=1, cdb_device=DEVICE_JMP, cdb_value=32'h12345678:
   - {0,DEVICE_ADDER,0} → unchanged.
   - {0,DEVICE_JMP,0} → {1,0,32'h12345678}.
   - {1,DEVICE_JMP,32'h87654321} → unchanged.
2. Reset and device filter, with device_now=DEVICE_ADDER:
   - Hold rst=1 for one edge → all outputs 0.
   - Drive in_hasInput=1, in_device=DEVICE_LOGIC, A={0,DEVICE_DM,0}, B={1,0,12345678} for one edge → out_buzy stays 0.
3. Accept and hold:
   - Same stimulus as scenario 2 but in_device=DEVICE_ADDER, algo ADDER_ALGO_ADD, cdb_buzy=0 → out_buzy=1, out_ready=0, out_valueA={0,DEVICE_DM,0}, out_valueB={1,0,12345678}.
   - Then drop in_hasInput for one edge → state unchanged.
4. CDB resolve with back-pressure:
   - cdb_buzy=1, cdb_device=DEVICE_DM, cdb_value=87654321, nxt_buzy=1 → after 1 edge out_valueA={1,0,87654321}, out_ready=1.
   - Further edges with cdb_buzy=0 → entry held, still ready.
5. Dispatch: nxt_buzy=0 → after 1 edge out_buzy=0, out_ready=0, all stored fields 0.
6. Corner cases:
   - Issue with operand tag equal to the same-cycle broadcast → stored operand already ready.
   - Issue attempt while buzy, including the dispatch cycle → ignored.
   - rst=1 while waiting → entry cleared on that edge.

Source files
------------

// File: rtl/buffer_in_if.sv
// ---------------------------------------------------------------------------
// buffer_in_if
// Bundles the signals between the issue stage, the common data bus (CDB), the
// downstream functional unit and one single-entry reservation buffer.
//
// Signals:
//   in_hasInput   issue stage presents an instruction this cycle
//   in_device     target device code of the issued instruction
//   in_algorithm  operation select for the unit
//   in_valueA/B   operands {ready[35], tag[34:32], value[31:0]}
//   device_now    this buffer's device code (tied constant)
//   cdb_buzy      CDB carries a valid broadcast this cycle
//   cdb_device    producing device tag of the broadcast
//   cdb_value     broadcast result
//   nxt_buzy      downstream unit busy, cannot accept
//   out_buzy      entry occupied
//   out_ready     entry occupied and both operands ready
//   out_algorithm stored operation
//   out_valueA/B  stored operands
//
// Modports: master = issue/CDB/unit side, slave = the buffer.
// ---------------------------------------------------------------------------
interface buffer_in_if;
   logic        in_hasInput;
   logic [2:0]  in_device;
   logic [1:0]  in_algorithm;
   logic [35:0] in_valueA;
   logic [35:0] in_valueB;
   logic [2:0]  device_now;
   logic        cdb_buzy;
   logic [2:0]  cdb_device;
   logic [31:0] cdb_value;
   logic        nxt_buzy;
   logic        out_buzy;
   logic        out_ready;
   logic [1:0]  out_algorithm;
   logic [35:0] out_valueA;
   logic [35:0] out_valueB;

   modport master (
      output in_hasInput, in_device, in_algorithm, in_valueA, in_valueB,
      output device_now, cdb_buzy, cdb_device, cdb_value, nxt_buzy,
      input  out_buzy, out_ready, out_algorithm, out_valueA, out_valueB
   );

   modport slave (
      input  in_hasInput, in_device, in_algorithm, in_valueA, in_valueB,
      input  device_now, cdb_buzy, cdb_device, cdb_value, nxt_buzy,
      output out_buzy, out_ready, out_algorithm, out_valueA, out_valueB
   );
endinterface

// File: rtl/buffer_in.sv
// ---------------------------------------------------------------------------
// buffer_in
// Single-entry Tomasulo reservation buffer in front of one functional unit.
// Accepts an instruction issued to its own device, snoops the CDB to resolve
// pending operands, and presents the instruction to the unit once both
// operands are ready. The unit consumes it on any cycle where out_ready=1 and
// nxt_buzy=0.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears the whole entry)
//   bus  buffer_in_if.slave (issue, CDB, downstream and stored-entry outputs)
// ---------------------------------------------------------------------------
module buffer_in (
   input  logic       clk,
   input  logic       rst,
   buffer_in_if.slave bus
);
   logic        r_buzy;
   logic [1:0]  r_algorithm;
   logic [35:0] r_value_a;
   logic [35:0] r_value_b;

   logic        w_ready;
   logic        w_dispatch;
   logic        w_accept;
   logic [35:0] w_src_a;
   logic [35:0] w_src_b;
   logic [35:0] w_fetch_a;
   logic [35:0] w_fetch_b;

   // A waiting operand whose tag matches a live broadcast takes the broadcast
   // value and becomes ready; a ready operand is never overwritten.
   function automatic logic [35:0] f_fetch_cdb(
      input logic [35:0] op,
      input logic        cdb_buzy,
      input logic [2:0]  cdb_device,
      input logic [31:0] cdb_value
   );
      logic [35:0] res;
      res = op;
      if (!op[35] && cdb_buzy && (cdb_device == op[34:32]))
         res = {1'b1, 3'b000, cdb_value};
      return res;
   endfunction

   // One fetch path per operand: snoops the stored operand while occupied,
   // the incoming operand while empty (same-cycle broadcast captured at issue).
   assign w_src_a   = r_buzy ? r_value_a : bus.in_valueA;
   assign w_src_b   = r_buzy ? r_value_b : bus.in_valueB;
   assign w_fetch_a = f_fetch_cdb(w_src_a, bus.cdb_buzy, bus.cdb_device, bus.cdb_value);
   assign w_fetch_b = f_fetch_cdb(w_src_b, bus.cdb_buzy, bus.cdb_device, bus.cdb_value);

   assign w_ready    = r_buzy & r_value_a[35] & r_value_b[35];
   assign w_dispatch = w_ready & ~bus.nxt_buzy;
   // Issue is only looked at while empty, so no refill on the dispatch cycle.
   assign w_accept   = ~r_buzy & bus.in_hasInput & (bus.in_device == bus.device_now);

   always_ff @(posedge clk) begin
      if (rst || w_dispatch) begin
         r_buzy      <= 1'b0;
         r_algorithm <= 2'b00;
         r_value_a   <= 36'd0;
         r_value_b   <= 36'd0;
      end else if (r_buzy) begin
         r_value_a   <= w_fetch_a;
         r_value_b   <= w_fetch_b;
      end else if (w_accept) begin
         r_buzy      <= 1'b1;
         r_algorithm <= bus.in_algorithm;
         r_value_a   <= w_fetch_a;
         r_value_b   <= w_fetch_b;
      end
   end

   assign bus.out_buzy      = r_buzy;
   assign bus.out_ready     = w_ready;
   assign bus.out_algorithm = r_algorithm;
   assign bus.out_valueA    = r_value_a;
   assign bus.out_valueB    = r_value_b;
endmodule

// File: tb/tb_buffer_in.sv
// ---------------------------------------------------------------------------
// tb_buffer_in
// Directed scenarios followed by randomized traffic for buffer_in, checked
// against a behavioural model of the reservation entry kept in the bench.
// ---------------------------------------------------------------------------
module tb_buffer_in;
   localparam logic [2:0] DEVICE_ADDER   = 3'd1;
   localparam logic [2:0] DEVICE_LOGIC   = 3'd2;
   localparam logic [2:0] DEVICE_JMP     = 3'd3;
   localparam logic [2:0] DEVICE_DM      = 3'd4;
   localparam logic [1:0] ADDER_ALGO_ADD = 2'd1;

   logic clk;
   logic rst;
   buffer_in_if bus ();

   buffer_in dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model of the entry
   logic        m_occ;
   logic [1:0]  m_algo;
   logic [35:0] m_a;
   logic [35:0] m_b;

   function automatic logic [35:0] snoop(input logic [35:0] op);
      if (op[35] == 1'b0 && bus.cdb_buzy == 1'b1 && bus.cdb_device == op[34:32])
         return {1'b1, 3'b000, bus.cdb_value};
      return op;
   endfunction

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      logic m_rdy;
      m_rdy = m_occ && m_a[35] && m_b[35];
      chk({tag, ".buzy"},  {35'd0, bus.out_buzy},      {35'd0, m_occ});
      chk({tag, ".ready"}, {35'd0, bus.out_ready},     {35'd0, m_rdy});
      chk({tag, ".algo"},  {34'd0, bus.out_algorithm}, {34'd0, m_algo});
      chk({tag, ".A"},     bus.out_valueA,             m_a);
      chk({tag, ".B"},     bus.out_valueB,             m_b);
   endtask

   // Advance one clock: compute the model's next entry from the inputs now
   // applied, then let the edge happen and compare just after it.
   task automatic step(input string tag);
      logic        n_occ;
      logic [1:0]  n_algo;
      logic [35:0] n_a, n_b;
      logic        rdy;
      n_occ = m_occ; n_algo = m_algo; n_a = m_a; n_b = m_b;
      rdy = m_occ && m_a[35] && m_b[35];
      if (rst || (rdy && !bus.nxt_buzy)) begin
         n_occ = 1'b0; n_algo = 2'd0; n_a = '0; n_b = '0;
      end else if (m_occ) begin
         n_a = snoop(m_a);
         n_b = snoop(m_b);
      end else if (bus.in_hasInput && bus.in_device == bus.device_now) begin
         n_occ = 1'b1; n_algo = bus.in_algorithm;
         n_a = snoop(bus.in_valueA);
         n_b = snoop(bus.in_valueB);
      end
      @(posedge clk);
      #1;
      m_occ = n_occ; m_algo = n_algo; m_a = n_a; m_b = n_b;
      chk_model(tag);
   endtask

   task automatic issue(input logic [2:0] dev, input logic [1:0] algo,
                        input logic [35:0] a, input logic [35:0] b);
      bus.in_hasInput  = 1'b1;
      bus.in_device    = dev;
      bus.in_algorithm = algo;
      bus.in_valueA    = a;
      bus.in_valueB    = b;
   endtask

   task automatic cdb(input logic busy, input logic [2:0] dev, input logic [31:0] val);
      bus.cdb_buzy   = busy;
      bus.cdb_device = dev;
      bus.cdb_value  = val;
   endtask

   initial begin
      m_occ = 1'b0; m_algo = '0; m_a = '0; m_b = '0;
      rst = 1'b1;
      bus.device_now = DEVICE_ADDER;
      bus.in_hasInput = 1'b0; bus.in_device = '0; bus.in_algorithm = '0;
      bus.in_valueA = '0; bus.in_valueB = '0;
      bus.nxt_buzy = 1'b0;
      cdb(1'b0, 3'd0, 32'd0);

      // reset state
      step("reset");
      chk("reset.buzy", {35'd0, bus.out_buzy}, 36'd0);
      chk("reset.A", bus.out_valueA, 36'd0);
      rst = 1'b0;

      // fetch-CDB: foreign tag unchanged, matching tag captured at issue
      cdb(1'b1, DEVICE_JMP, 32'h12345678);
      bus.nxt_buzy = 1'b1;
      issue(DEVICE_ADDER, 2'd2, {1'b0, DEVICE_ADDER, 32'd0}, {1'b0, DEVICE_JMP, 32'd0});
      step("fetch1");
      chk("fetch.tag_mismatch", bus.out_valueA, {1'b0, DEVICE_ADDER, 32'd0});
      chk("fetch.tag_match", bus.out_valueB, {1'b1, 3'b000, 32'h12345678});
      rst = 1'b1; bus.in_hasInput = 1'b0;
      step("fetch.rst");
      rst = 1'b0;
      issue(DEVICE_ADDER, 2'd3, {1'b1, DEVICE_JMP, 32'h87654321}, {1'b1, 3'b000, 32'h5});
      step("fetch2");
      chk("fetch.ready_kept", bus.out_valueA, {1'b1, DEVICE_JMP, 32'h87654321});
      chk("fetch.out_ready", {35'd0, bus.out_ready}, 36'd1);
      rst = 1'b1; bus.in_hasInput = 1'b0;
      cdb(1'b0, 3'd0, 32'd0);
      step("s2.rst");
      chk("s2.rst.A", bus.out_valueA, 36'd0);
      chk("s2.rst.algo", {34'd0, bus.out_algorithm}, 36'd0);
      rst = 1'b0;

      // device filter
      issue(DEVICE_LOGIC, ADDER_ALGO_ADD, {1'b0, DEVICE_DM, 32'd0}, {1'b1, 3'b000, 32'd12345678});
      step("filter");
      chk("filter.buzy", {35'd0, bus.out_buzy}, 36'd0);

      // accept and hold
      bus.in_device = DEVICE_ADDER;
      step("accept");
      chk("accept.buzy", {35'd0, bus.out_buzy}, 36'd1);
      chk("accept.ready", {35'd0, bus.out_ready}, 36'd0);
      chk("accept.A", bus.out_valueA, {1'b0, DEVICE_DM, 32'd0});
      chk("accept.B", bus.out_valueB, {1'b1, 3'b000, 32'd12345678});
      chk("accept.algo", {34'd0, bus.out_algorithm}, {34'd0, ADDER_ALGO_ADD});
      bus.in_hasInput = 1'b0;
      step("hold");
      // issue while busy is ignored
      issue(DEVICE_ADDER, 2'd3, {1'b1, 3'b000, 32'hdead}, {1'b1, 3'b000, 32'hbeef});
      step("busy_issue");
      chk("busy_issue.A", bus.out_valueA, {1'b0, DEVICE_DM, 32'd0});
      bus.in_hasInput = 1'b0;

      // CDB resolve with back-pressure
      cdb(1'b1, DEVICE_DM, 32'd87654321);
      step("resolve");
      chk("resolve.A", bus.out_valueA, {1'b1, 3'b000, 32'd87654321});
      chk("resolve.ready", {35'd0, bus.out_ready}, 36'd1);
      cdb(1'b0, 3'd0, 32'd0);
      step("backpressure1");
      step("backpressure2");
      chk("backpressure.buzy", {35'd0, bus.out_buzy}, 36'd1);

      // dispatch, with an issue attempt in the same cycle
      bus.nxt_buzy = 1'b0;
      issue(DEVICE_ADDER, 2'd2, {1'b1, 3'b000, 32'h1}, {1'b1, 3'b000, 32'h2});
      step("dispatch");
      chk("dispatch.buzy", {35'd0, bus.out_buzy}, 36'd0);
      chk("dispatch.A", bus.out_valueA, 36'd0);
      chk("dispatch.B", bus.out_valueB, 36'd0);
      bus.in_hasInput = 1'b0;
      step("idle");

      // reset while waiting
      issue(DEVICE_ADDER, 2'd2, {1'b0, DEVICE_JMP, 32'd0}, {1'b0, DEVICE_DM, 32'd0});
      step("wait");
      bus.in_hasInput = 1'b0;
      rst = 1'b1;
      step("wait.rst");
      chk("wait.rst.buzy", {35'd0, bus.out_buzy}, 36'd0);
      rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         bus.in_hasInput  = $urandom_range(0, 1);
         bus.in_device    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : DEVICE_ADDER;
         bus.in_algorithm = 2'($urandom_range(0, 3));
         bus.in_valueA    = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom)};
         bus.in_valueB    = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom)};
         bus.nxt_buzy     = ($urandom_range(0, 2) == 0);
         cdb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom));
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
